// File: rtl/se_weight_sequencer_pkg.sv
// Shared squeeze-excitation definitions: weight-loader state encoding and
// FC layer sizing helpers used by the sequencer and the FC layer parameters.
package se_weight_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_FC1 = 2'd1,
        LOAD_FC2 = 2'd2,
        DONE     = 2'd3
    } se_wt_state_t;

    // Weight count of one SE FC layer: C inputs times C/ratio outputs (same for both layers).
    function automatic int unsigned se_fc_weights(input int unsigned channels,
                                                  input int unsigned ratio);
        return channels * (channels / ratio);
    endfunction

    function automatic int unsigned se_cnt_width(input int unsigned fc1_weights,
                                                 input int unsigned fc2_weights);
        int unsigned largest;
        largest = (fc1_weights > fc2_weights) ? fc1_weights : fc2_weights;
        return (largest > 2) ? $clog2(largest) : 1;
    endfunction

endpackage

// File: rtl/se_weight_sequencer_frame_monitor.sv
// Tracks whether the SE feature stream is inside a frame, so a weight reload
// can be deferred to a frame boundary.
module se_frame_monitor (
    input  logic clk,
    input  logic rst,
    input  logic feat_tvalid_i,
    input  logic feat_tready_i,
    input  logic feat_tlast_i,
    output logic frame_active_o,
    output logic frame_idle_o
);

    logic feat_hs;
    logic frame_active_q;
    logic frame_active_d;

    assign feat_hs = feat_tvalid_i && feat_tready_i;

    always_comb begin
        frame_active_d = frame_active_q;
        if (feat_hs) begin
            frame_active_d = !feat_tlast_i;
        end
    end

    // NOTE: reset is synchronous and active-high, so it lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_active_q <= 1'b0;
        end else begin
            frame_active_q <= frame_active_d;
        end
    end

    // A frame ending on this very handshake already counts as idle.
    assign frame_idle_o   = !frame_active_q || (feat_hs && feat_tlast_i);
    assign frame_active_o = frame_active_q;

endmodule

// File: rtl/se_weight_sequencer.sv
// Routes one weight stream to the SE reduction (FC1) and expansion (FC2) layers,
// deferring reloads to feature-frame boundaries. Macro SE_WT_TLAST_CHECK_EN
// enables the sticky tlast-mismatch flag err_tlast.
module se_weight_sequencer
    import se_weight_sequencer_pkg::*;
#(
    parameter int WEIGHT_WIDTH    = 8,
    parameter int NUM_CHANNELS    = 64,
    parameter int REDUCTION_RATIO = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WEIGHT_WIDTH-1:0] s_wt_tdata,
    input  logic                    s_wt_tvalid,
    output logic                    s_wt_tready,
    input  logic                    s_wt_tlast,
    output logic [WEIGHT_WIDTH-1:0] fc1_wt_tdata,
    output logic                    fc1_wt_tvalid,
    input  logic                    fc1_wt_tready,
    output logic [WEIGHT_WIDTH-1:0] fc2_wt_tdata,
    output logic                    fc2_wt_tvalid,
    input  logic                    fc2_wt_tready,
    input  logic                    feat_tvalid,
    input  logic                    feat_tready,
    input  logic                    feat_tlast,
    output logic                    feat_enable,
    output logic                    weights_loaded,
    output logic                    load_done,
    output logic                    err_tlast
);

    localparam int FC1_WEIGHTS = se_fc_weights(NUM_CHANNELS, REDUCTION_RATIO);
    localparam int FC2_WEIGHTS = se_fc_weights(NUM_CHANNELS, REDUCTION_RATIO);
    localparam int CNT_W       = se_cnt_width(FC1_WEIGHTS, FC2_WEIGHTS);

    localparam logic [CNT_W-1:0] FC1_LAST = CNT_W'(FC1_WEIGHTS - 1);
    localparam logic [CNT_W-1:0] FC2_LAST = CNT_W'(FC2_WEIGHTS - 1);

    se_wt_state_t     state_q, state_d;
    logic [CNT_W-1:0] wt_cnt_q, wt_cnt_d;
    logic             pending_q, pending_d;
    logic             load_done_q, load_done_d;

    logic frame_active;
    logic frame_idle;
    logic reload_req;
    logic enter_load;
    logic wt_accept;
    logic wt_final;

    se_frame_monitor u_frame_monitor (
        .clk            (clk),
        .rst            (rst),
        .feat_tvalid_i  (feat_tvalid),
        .feat_tready_i  (feat_tready),
        .feat_tlast_i   (feat_tlast),
        .frame_active_o (frame_active),
        .frame_idle_o   (frame_idle)
    );

    // Weight path is pure combinational steering: zero-cycle latency, full throughput.
    assign fc1_wt_tdata = s_wt_tdata;
    assign fc2_wt_tdata = s_wt_tdata;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        s_wt_tready   = 1'b0;
        fc1_wt_tvalid = 1'b0;
        fc2_wt_tvalid = 1'b0;
        wt_final      = 1'b0;
        unique case (state_q)
            LOAD_FC1: begin
                s_wt_tready   = fc1_wt_tready;
                fc1_wt_tvalid = s_wt_tvalid;
                wt_final      = (wt_cnt_q == FC1_LAST);
            end
            LOAD_FC2: begin
                s_wt_tready   = fc2_wt_tready;
                fc2_wt_tvalid = s_wt_tvalid;
                wt_final      = (wt_cnt_q == FC2_LAST);
            end
            default: ;
        endcase
    end

    assign wt_accept  = s_wt_tvalid && s_wt_tready;
    assign reload_req = start || pending_q;
    assign enter_load = (state_q == IDLE || state_q == DONE) && reload_req && frame_idle;

    always_comb begin
        state_d     = state_q;
        wt_cnt_d    = wt_cnt_q;
        pending_d   = pending_q;
        load_done_d = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (enter_load) begin
                    state_d   = LOAD_FC1;
                    wt_cnt_d  = '0;
                    pending_d = 1'b0;
                end else if (start) begin
                    pending_d = 1'b1;
                end
            end
            LOAD_FC1: begin
                if (wt_accept) begin
                    if (wt_final) begin
                        state_d  = LOAD_FC2;
                        wt_cnt_d = '0;
                    end else begin
                        wt_cnt_d = wt_cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_FC2: begin
                if (wt_accept) begin
                    if (wt_final) begin
                        state_d     = DONE;
                        wt_cnt_d    = '0;
                        load_done_d = 1'b1;
                    end else begin
                        wt_cnt_d = wt_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wt_cnt_q    <= '0;
            pending_q   <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wt_cnt_q    <= wt_cnt_d;
            pending_q   <= pending_d;
            load_done_q <= load_done_d;
        end
    end

    assign weights_loaded = (state_q == DONE);
    assign load_done      = load_done_q;
    // With a reload requested, upstream may only finish the frame already in flight.
    assign feat_enable    = (state_q == DONE) && (!reload_req || frame_active);

`ifdef SE_WT_TLAST_CHECK_EN
    logic err_tlast_q, err_tlast_d;

    always_comb begin
        err_tlast_d = err_tlast_q;
        if (enter_load) begin
            err_tlast_d = 1'b0;
        end else if (wt_accept && (s_wt_tlast != wt_final)) begin
            err_tlast_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_tlast_q <= 1'b0;
        end else begin
            err_tlast_q <= err_tlast_d;
        end
    end

    assign err_tlast = err_tlast_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_wt_tlast;
    assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_se_weight_sequencer.sv
// Directed bench for se_weight_sequencer with C=8, ratio 4 (16 weights per layer),
// checked every cycle against a beat-position model plus literal spot checks.
module tb_se_weight_sequencer;

    localparam int W         = 8;
    localparam int PER_LAYER = 16;
    localparam int TOTAL     = 32;
`ifdef SE_WT_TLAST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] s_wt_tdata;
    logic         s_wt_tvalid;
    logic         s_wt_tready;
    logic         s_wt_tlast;
    logic [W-1:0] fc1_wt_tdata;
    logic         fc1_wt_tvalid;
    logic         fc1_wt_tready;
    logic [W-1:0] fc2_wt_tdata;
    logic         fc2_wt_tvalid;
    logic         fc2_wt_tready;
    logic         feat_tvalid;
    logic         feat_tready;
    logic         feat_tlast;
    logic         feat_enable;
    logic         weights_loaded;
    logic         load_done;
    logic         err_tlast;

    int total = 0;
    int bad   = 0;

    se_weight_sequencer #(
        .WEIGHT_WIDTH    (W),
        .NUM_CHANNELS    (8),
        .REDUCTION_RATIO (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_wt_tdata     (s_wt_tdata),
        .s_wt_tvalid    (s_wt_tvalid),
        .s_wt_tready    (s_wt_tready),
        .s_wt_tlast     (s_wt_tlast),
        .fc1_wt_tdata   (fc1_wt_tdata),
        .fc1_wt_tvalid  (fc1_wt_tvalid),
        .fc1_wt_tready  (fc1_wt_tready),
        .fc2_wt_tdata   (fc2_wt_tdata),
        .fc2_wt_tvalid  (fc2_wt_tvalid),
        .fc2_wt_tready  (fc2_wt_tready),
        .feat_tvalid    (feat_tvalid),
        .feat_tready    (feat_tready),
        .feat_tlast     (feat_tlast),
        .feat_enable    (feat_enable),
        .weights_loaded (weights_loaded),
        .load_done      (load_done),
        .err_tlast      (err_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load is "busy" with m_pos beats accepted; beats 0..15 belong to fc1, 16..31 to fc2.
    bit m_valid = 1'b0;
    bit m_busy, m_has, m_pend, m_frame, m_err, m_done;
    int m_pos;

    always @(posedge clk) begin
        bit hs_f, idle_f, acc;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_has   = 1'b0;
            m_pend  = 1'b0;
            m_frame = 1'b0;
            m_err   = 1'b0;
            m_done  = 1'b0;
            m_pos   = 0;
        end else if (m_valid) begin
            hs_f   = feat_tvalid && feat_tready;
            idle_f = !m_frame || (hs_f && feat_tlast);
            m_done = 1'b0;
            if (m_busy) begin
                acc = s_wt_tvalid && ((m_pos < PER_LAYER) ? fc1_wt_tready : fc2_wt_tready);
                if (acc) begin
                    if (CHK && (s_wt_tlast != ((m_pos % PER_LAYER) == PER_LAYER - 1)))
                        m_err = 1'b1;
                    m_pos++;
                    if (m_pos == TOTAL) begin
                        m_busy = 1'b0;
                        m_has  = 1'b1;
                        m_done = 1'b1;
                        m_pos  = 0;
                    end
                end
            end else if ((start || m_pend) && idle_f) begin
                m_busy = 1'b1;
                m_has  = 1'b0;
                m_pend = 1'b0;
                m_err  = 1'b0;
                m_pos  = 0;
            end else if (start) begin
                m_pend = 1'b1;
            end
            if (hs_f) m_frame = !feat_tlast;
        end
    end

    // ---------------- per-cycle compare ----------------
    int fc1_got = 0;
    int fc2_got = 0;

    always @(negedge clk) begin
        bit in_fc1, in_fc2;
        if (m_valid) begin
            in_fc1 = m_busy && (m_pos < PER_LAYER);
            in_fc2 = m_busy && (m_pos >= PER_LAYER);
            check("s_wt_tready", s_wt_tready,
                  (in_fc1 && fc1_wt_tready) || (in_fc2 && fc2_wt_tready));
            check("fc1_wt_tvalid", fc1_wt_tvalid, in_fc1 && s_wt_tvalid);
            check("fc2_wt_tvalid", fc2_wt_tvalid, in_fc2 && s_wt_tvalid);
            check("fc1_wt_tdata", fc1_wt_tdata, s_wt_tdata);
            check("fc2_wt_tdata", fc2_wt_tdata, s_wt_tdata);
            check("weights_loaded", weights_loaded, m_has);
            check("load_done", load_done, m_done);
            check("feat_enable", feat_enable, m_has && (!(start || m_pend) || m_frame));
            check("err_tlast", err_tlast, m_err);
            if (fc1_wt_tvalid && fc1_wt_tready) begin
                fc1_got++;
                check("fc1_beat_value", fc1_wt_tdata, 32'(m_pos));
            end
            if (fc2_wt_tvalid && fc2_wt_tready) begin
                fc2_got++;
                check("fc2_beat_value", fc2_wt_tdata, 32'(m_pos));
            end
        end
    end

    // ---------------- stimulus ----------------
    int beat_cycles;
    int snap1, snap2;

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Sends beats first..first+n-1 of a load; data equals beat index, tlast on
    // each layer's final beat, flipped on bad_idx. Optionally toggles fc2 ready.
    task automatic send(input int first, input int n, input int bad_idx, input bit toggle2);
        int  waited;
        bit  acc;
        for (int i = first; i < first + n; i++) begin
            s_wt_tdata  = W'(i);
            s_wt_tlast  = (((i % PER_LAYER) == PER_LAYER - 1) != (i == bad_idx));
            s_wt_tvalid = 1'b1;
            waited      = 0;
            forever begin
                @(negedge clk);
                acc = s_wt_tready;
                @(posedge clk); #1;
                beat_cycles++;
                if (toggle2 && i >= PER_LAYER) fc2_wt_tready = !fc2_wt_tready;
                if (acc) break;
                waited++;
                if (waited > 50) begin
                    total++;
                    bad++;
                    $display("FAIL beat_timeout: beat %0d never accepted, waited %0d cycles", i, waited);
                    s_wt_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_wt_tvalid = 1'b0;
        s_wt_tlast  = 1'b0;
    endtask

    task automatic snapshot();
        snap1       = fc1_got;
        snap2       = fc2_got;
        beat_cycles = 0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        s_wt_tdata    = '0;
        s_wt_tvalid   = 1'b0;
        s_wt_tlast    = 1'b0;
        fc1_wt_tready = 1'b1;
        fc2_wt_tready = 1'b1;
        feat_tvalid   = 1'b0;
        feat_tready   = 1'b1;
        feat_tlast    = 1'b0;
        idle_cycles(2);
        rst = 1'b0;

        // Reset state, with a visible weight beat offered to prove IDLE blocks it.
        s_wt_tdata  = 8'hA5;
        s_wt_tvalid = 1'b1;
        @(negedge clk);
        check("rst_tready", s_wt_tready, 0);
        check("rst_fc1_valid", fc1_wt_tvalid, 0);
        check("rst_fc2_valid", fc2_wt_tvalid, 0);
        check("rst_loaded", weights_loaded, 0);
        check("rst_feat_enable", feat_enable, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err", err_tlast, 0);
        check("rst_fc2_data", fc2_wt_tdata, 8'hA5);
        @(posedge clk); #1;
        s_wt_tvalid = 1'b0;

        // Full-rate load: 32 beats in 32 cycles, 16 per layer.
        snapshot();
        pulse_start();
        send(0, TOTAL, -1, 1'b0);
        @(negedge clk);
        check("l1_load_done", load_done, 1);
        check("l1_loaded", weights_loaded, 1);
        check("l1_feat_enable", feat_enable, 1);
        check("l1_fc1_beats", fc1_got - snap1, 16);
        check("l1_fc2_beats", fc2_got - snap2, 16);
        check("l1_cycles", beat_cycles, 32);
        @(negedge clk);
        check("l1_done_pulse_end", load_done, 0);
        @(posedge clk); #1;

        // fc2 ready toggling: each fc2 beat after the first costs two cycles.
        snapshot();
        pulse_start();
        send(0, TOTAL, -1, 1'b1);
        fc2_wt_tready = 1'b1;
        check("tog_fc2_beats", fc2_got - snap2, 16);
        check("tog_fc1_beats", fc1_got - snap1, 16);
        check("tog_cycles", beat_cycles, 47);
        idle_cycles(2);

        // Reload requested mid-frame waits for the frame's tlast handshake.
        feat_tvalid = 1'b1;
        feat_tlast  = 1'b0;
        @(posedge clk); #1;
        feat_tvalid = 1'b0;
        pulse_start();
        idle_cycles(3);
        @(negedge clk);
        check("defer_loaded", weights_loaded, 1);
        check("defer_feat_enable", feat_enable, 1);
        check("defer_tready", s_wt_tready, 0);
        @(posedge clk); #1;
        feat_tvalid = 1'b1;
        feat_tlast  = 1'b1;
        @(negedge clk);
        check("defer_last_enable", feat_enable, 1);
        @(posedge clk); #1;
        feat_tvalid = 1'b0;
        feat_tlast  = 1'b0;
        @(negedge clk);
        check("defer_entered_loaded", weights_loaded, 0);
        check("defer_entered_enable", feat_enable, 0);
        check("defer_entered_tready", s_wt_tready, 1);
        @(posedge clk); #1;
        snapshot();
        send(0, TOTAL, -1, 1'b0);
        check("defer_fc2_beats", fc2_got - snap2, 16);
        idle_cycles(2);

        // Misplaced tlast on beat 7: flag (when built in) but sequencing unaffected.
        snapshot();
        pulse_start();
        send(0, TOTAL, 7, 1'b0);
        @(negedge clk);
        check("tlast_err_flag", err_tlast, CHK);
        check("tlast_load_done", load_done, 1);
        check("tlast_fc2_beats", fc2_got - snap2, 16);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        check("tlast_err_cleared", err_tlast, 0);
        @(posedge clk); #1;
        send(0, TOTAL, -1, 1'b0);
        idle_cycles(2);

        // Reset after 10 beats discards the partial load.
        pulse_start();
        send(0, 10, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        s_wt_tdata  = 8'h3C;
        s_wt_tvalid = 1'b1;
        @(negedge clk);
        check("mid_rst_tready", s_wt_tready, 0);
        check("mid_rst_fc1_valid", fc1_wt_tvalid, 0);
        check("mid_rst_loaded", weights_loaded, 0);
        check("mid_rst_feat_enable", feat_enable, 0);
        check("mid_rst_fc1_data", fc1_wt_tdata, 8'h3C);
        @(posedge clk); #1;
        s_wt_tvalid = 1'b0;
        snapshot();
        pulse_start();
        send(0, TOTAL, -1, 1'b0);
        @(negedge clk);
        check("post_rst_load_done", load_done, 1);
        check("post_rst_fc1_beats", fc1_got - snap1, 16);
        @(posedge clk); #1;

        // start during LOAD_FC1 is ignored: exactly one load, then DONE stays.
        snapshot();
        pulse_start();
        send(0, 5, -1, 1'b0);
        pulse_start();
        send(5, TOTAL - 5, -1, 1'b0);
        idle_cycles(5);
        @(negedge clk);
        check("ign_loaded", weights_loaded, 1);
        check("ign_tready", s_wt_tready, 0);
        check("ign_feat_enable", feat_enable, 1);
        check("ign_fc1_beats", fc1_got - snap1, 16);
        check("ign_fc2_beats", fc2_got - snap2, 16);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/se_weight_sequencer.md
# se_weight_sequencer

Loads weights into the squeeze-excitation block. It takes one AXI4-Stream weight source, routes the first `FC1_WEIGHTS` beats to the reduction FC layer and the next `FC2_WEIGHTS` beats to the expansion FC layer, and signals when both are loaded. It also watches the SE feature input stream, so a weight reload never starts in the middle of a frame.

## Interface
- `WEIGHT_WIDTH`, 8: weight beat width.
- `NUM_CHANNELS`, 64: SE channel count C.
- `REDUCTION_RATIO`, 4: bottleneck ratio; R = C/REDUCTION_RATIO.
- Derived: FC1_WEIGHTS = C*R; FC2_WEIGHTS = R*C; CNT_W = $clog2(max(FC1_WEIGHTS, FC2_WEIGHTS)).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse requesting a (re)load.
- `s_wt_tdata`  in  WEIGHT_WIDTH  weight source data.
- `s_wt_tvalid` / `s_wt_tready`  in / out  1  weight source handshake.
- `s_wt_tlast`  in  1  marks the last beat of each layer's weight set.
- `fc1_wt_tdata`, `fc2_wt_tdata`  out  WEIGHT_WIDTH  fan-out of `s_wt_tdata`.
- `fc1_wt_tvalid` / `fc1_wt_tready`, `fc2_wt_tvalid` / `fc2_wt_tready`  out / in  1  per-layer handshake.
- `feat_tvalid`, `feat_tready`, `feat_tlast`  in  1  monitor taps on the SE feature input.
- `feat_enable`  out  1  upstream may start or continue feature beats.
- `weights_loaded`  out  1  high in state DONE.
- `load_done`  out  1  one-cycle pulse on load completion.
- `err_tlast`  out  1  sticky tlast-mismatch flag.

## Operation
- States: IDLE, LOAD_FC1, LOAD_FC2, DONE.
- Weight handshake (combinational pass-through):
  - `fcN_wt_tvalid` = `s_wt_tvalid` && state==LOAD_FCN.
  - `s_wt_tready` = `fc1_wt_tready` in LOAD_FC1, `fc2_wt_tready` in LOAD_FC2, else 0.
  - Data fans out to both layers unconditionally.
- `wt_cnt` (CNT_W bits) increments on each accepted beat.
  - LOAD_FC1: on the accepted beat with wt_cnt==FC1_WEIGHTS-1, go to LOAD_FC2 and clear wt_cnt.
  - LOAD_FC2: on the accepted beat with wt_cnt==FC2_WEIGHTS-1, go to DONE, clear wt_cnt, assert `load_done` next cycle.
  - The count is authoritative; tlast never changes sequencing.
- `frame_active`:
  - Set on a feature handshake (`feat_tvalid` && `feat_tready`) with `feat_tlast`=0.
  - Cleared on a feature handshake with `feat_tlast`=1.
  - frame_idle = !frame_active || (handshake && `feat_tlast`).
- `pending` flag:
  - Set by `start` in DONE or IDLE.
  - Cleared when the reload begins.
- IDLE/DONE → LOAD_FC1 when (`start` || `pending`) && frame_idle. Otherwise `pending` holds the request.
- `start` during LOAD_FC1/LOAD_FC2 is ignored. It does not restart the load and does not set `pending`.
- `feat_enable`:
  - 1 in DONE while no reload is pending.
  - With a reload pending, 1 only while `frame_active` (the current frame finishes), then 0.
  - 0 in all other states.
- Reset mid-load: state goes to IDLE, counters clear, partial weights are discarded. Software must issue `start` again.

## Timing
- Reset values: state IDLE; `s_wt_tready`, `fc1_wt_tvalid`, `fc2_wt_tvalid`, `feat_enable`, `weights_loaded`, `load_done`, `err_tlast` all 0; `fcN_wt_tdata` follows input.
- Latency:
  - Zero cycles on the weight path.
  - `start` in IDLE with frame idle: `s_wt_tready` can assert the following cycle.
  - `load_done` and `weights_loaded` rise the cycle after the final FC2 handshake.
- Full throughput: 1 beat/cycle when the downstream layers are ready. Total load is FC1_WEIGHTS+FC2_WEIGHTS cycles minimum.
- `start` coinciding with a feature tlast handshake is accepted that same cycle.

## Configuration
- `SE_WT_TLAST_CHECK_EN` defined:
  - `err_tlast` sets when `s_wt_tlast`=1 on a non-final beat of a layer, or `s_wt_tlast`=0 on a final beat.
  - Sticky; cleared only by reset or by entering LOAD_FC1.
- Undefined: `s_wt_tlast` is ignored and `err_tlast` is tied 0.

## Structure
- Shared SE package holds:
  - the state enum `se_wt_state_t`;
  - a function computing FC1_WEIGHTS/FC2_WEIGHTS from C and ratio, reused by the FC layer parameters.
- Sub-module `se_frame_monitor` holds the `frame_active` tracking and frame_idle output. Everything else stays in the top module.

## Test plan
Configuration for all scenarios: C=8, REDUCTION_RATIO=4 (R=2, 16 weights per layer).
- Reset, then `start`, then 32 beats 0..31 with both readies held 1: beats 0–15 appear on fc1, 16–31 on fc2. `load_done` pulses the cycle after beat 31; `weights_loaded`=1; `feat_enable`=1.
- `fc2_wt_tready` toggled 1,0,1,0 during LOAD_FC2: `s_wt_tready` mirrors it, no beat is lost or duplicated, `fc1_wt_tvalid` stays 0.
- DONE, feature frame mid-way (`frame_active`=1), `start` pulsed: state stays DONE and `feat_enable` stays 1 until the tlast handshake. LOAD_FC1 is entered on the cycle after the tlast handshake; `feat_enable`=0 from then on.
- With `SE_WT_TLAST_CHECK_EN` defined, tlast on beat 7: `err_tlast`=1 from the next cycle, loading still completes after 32 beats, and a new `start` clears it.
- `rst` asserted after 10 beats: next cycle state is IDLE with all outputs 0. A fresh `start` plus 32 beats completes normally.
- `start` pulsed during LOAD_FC1: no effect. After completion the state stays DONE with no reload.
